// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
//   Time-multiplexes up to 8 seven-segment digits through one shared decoder.
//   Each digit slot has two phases. First, all anodes are held off for a short
//   ghost-suppression window while the digit's nibble is already on num. Then
//   the digit's anode is lit for the rest of the slot.
//   Display data is double-buffered. load captures into a shadow copy, and the
//   shadow is promoted to the active copy only when digit DIGITS-1 wraps to
//   digit 0, so a frame is never torn.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | not scanning; anodes off; idx=0, cnt=0; load writes shadow+active
//   BLANK | slot start; anodes off; num/dp show digit idx; cnt 0..BLANK_CYCLES-1
//   SHOW  | anode idx lit unless blanked; cnt BLANK_CYCLES..REFRESH_DIV-1
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   enable      in   1 = scan, 0 = idle with anodes off
//   load        in   strobe: capture value/dp_mask/blank_mask into shadow
//   value       in   digit nibbles, digit i = value[4i+3:4i]
//   dp_mask     in   decimal-point request per digit
//   blank_mask  in   1 = digit never lit
//   num         out  nibble to the decoder
//   dp          out  decimal point of the current digit
//   anode       out  one-hot digit enable, active-high
//   frame       out  one-cycle pulse on the digit DIGITS-1 -> 0 wrap
module sseg_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [3:0]            num,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNTW = $clog2(REFRESH_DIV);

    localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(REFRESH_DIV - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t               state;
    logic [IDXW-1:0]      idx;
    logic [CNTW-1:0]      cnt;

    logic [4*DIGITS-1:0]  sh_val;
    logic [DIGITS-1:0]    sh_dp;
    logic [DIGITS-1:0]    sh_blank;
    logic [4*DIGITS-1:0]  act_val;
    logic [DIGITS-1:0]    act_dp;
    logic [DIGITS-1:0]    act_blank;

    logic                 slot_end;
    logic                 wrap;
    logic                 take_load;
    logic [IDXW-1:0]      nxt_idx;
    logic [IDXW-1:0]      sel_idx;
    logic [4*DIGITS-1:0]  eff_val;
    logic [DIGITS-1:0]    eff_dp;
    logic [DIGITS-1:0]    eff_blank;
    logic [3:0]           nxt_num;
    logic                 nxt_dp;
    logic [DIGITS-1:0]    show_anode;

    always_comb begin
        slot_end  = (state == SHOW) && (cnt == CNT_LAST);
        wrap      = slot_end && (idx == IDX_LAST);
        // A load goes straight to the active copy when idle, or when it
        // coincides with the frame wrap (bypass the shadow).
        take_load = load && ((state == IDLE) || wrap);
        nxt_idx   = (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
        sel_idx   = (state == IDLE) ? '0 : nxt_idx;

        // Data that will be active for the slot about to start.
        if (take_load) begin
            eff_val   = value;
            eff_dp    = dp_mask;
            eff_blank = blank_mask;
        end else if (wrap) begin
            eff_val   = sh_val;
            eff_dp    = sh_dp;
            eff_blank = sh_blank;
        end else begin
            eff_val   = act_val;
            eff_dp    = act_dp;
            eff_blank = act_blank;
        end

        nxt_num    = 4'd0;
        nxt_dp     = 1'b0;
        show_anode = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDXW'(i) == sel_idx) begin
                nxt_num = eff_val[4*i +: 4];
                nxt_dp  = eff_dp[i];
            end
            if (IDXW'(i) == idx) begin
                show_anode[i] = ~act_blank[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            num       <= 4'd0;
            dp        <= 1'b0;
            anode     <= '0;
            frame     <= 1'b0;
        end else begin
            frame <= 1'b0;

            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_mask;
                sh_blank <= blank_mask;
            end

            // Dropping enable cancels a pending wrap, so no promotion there.
            if (take_load && (enable || state == IDLE)) begin
                act_val   <= value;
                act_dp    <= dp_mask;
                act_blank <= blank_mask;
            end else if (wrap && enable) begin
                act_val   <= sh_val;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
            end

            if (!enable) begin
                state <= IDLE;
                idx   <= '0;
                cnt   <= '0;
                anode <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= BLANK;
                        idx   <= '0;
                        cnt   <= '0;
                        anode <= '0;
                        num   <= nxt_num;
                        dp    <= nxt_dp;
                    end
                    BLANK: begin
                        cnt <= cnt + CNTW'(1);
                        if (cnt == BLANK_LAST) begin
                            state <= SHOW;
                            anode <= show_anode;
                        end
                    end
                    SHOW: begin
                        if (slot_end) begin
                            state <= BLANK;
                            cnt   <= '0;
                            idx   <= nxt_idx;
                            anode <= '0;
                            num   <= nxt_num;
                            dp    <= nxt_dp;
                            frame <= wrap;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                        cnt   <= '0;
                        anode <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Every slot is 8 cycles (2 blank + 6 lit) and a frame is 32.
// Inputs are driven and outputs sampled on the falling edge.
module tb_sseg_scan_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  num;
    logic        dp;
    logic [3:0]  anode;
    logic        frame;

    int n_cmp = 0;
    int n_err = 0;

    sseg_scan_controller #(
        .DIGITS(4),
        .REFRESH_DIV(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .load(load),
        .value(value),
        .dp_mask(dp_mask),
        .blank_mask(blank_mask),
        .num(num),
        .dp(dp),
        .anode(anode),
        .frame(frame)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checks cycles c0..c1-1 of a frame against hand-supplied frame contents.
    // Cycle c is digit c/8, phase c%8; phases 0..1 are blank. An optional
    // load of (lv, ld, lb) is driven during cycle load_c.
    task automatic run_span(input logic [15:0] vals, input logic [3:0] dpm,
                            input logic [3:0] blk, input bit pulse,
                            input int c0, input int c1, input int load_c,
                            input logic [15:0] lv, input logic [3:0] ld,
                            input logic [3:0] lb);
        for (int c = c0; c < c1; c++) begin
            automatic int d = c / 8;
            automatic int p = c % 8;
            automatic logic [15:0] v = vals >> (4 * d);
            automatic logic [3:0] exp_an = (p < 2 || blk[d]) ? 4'b0000 : 4'(1 << d);
            chk($sformatf("num c%0d", c), 32'(num), 32'(v[3:0]));
            chk($sformatf("anode c%0d", c), 32'(anode), 32'(exp_an));
            chk($sformatf("dp c%0d", c), 32'(dp), 32'(dpm[d]));
            chk($sformatf("frame c%0d", c), 32'(frame), 32'((c == 0) && pulse));
            if (c == load_c) begin
                load       = 1'b1;
                value      = lv;
                dp_mask    = ld;
                blank_mask = lb;
            end else begin
                load = 1'b0;
            end
            @(negedge clock);
        end
        load = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        value      = 16'h0;
        dp_mask    = 4'h0;
        blank_mask = 4'h0;
        #1;
        chk("anode in reset", 32'(anode), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk($sformatf("idle outs %0d", i), 32'({num, dp, anode, frame}), 32'h0);
        end

        // 2: load while idle, then scan one frame; digit-1 load goes to shadow
        load  = 1'b1;
        value = 16'h4321;
        @(negedge clock);
        load   = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        run_span(16'h4321, 4'b0000, 4'b0000, 1'b0, 0, 32, 11,
                 16'hABCD, 4'b0001, 4'b1000);

        // 3/4: new frame shows ABCD with masks; two loads, the last wins
        run_span(16'hABCD, 4'b0001, 4'b1000, 1'b1, 0, 16, 5,
                 16'h1111, 4'b0000, 4'b0000);
        run_span(16'hABCD, 4'b0001, 4'b1000, 1'b0, 16, 32, 20,
                 16'h4321, 4'b0001, 4'b1000);

        // digit 3 blanked with num=4, dp only on digit 0; load on the wrap cycle
        run_span(16'h4321, 4'b0001, 4'b1000, 1'b1, 0, 32, 31,
                 16'h5678, 4'b0000, 4'b0000);

        // bypass load shows from digit 0 of this frame
        run_span(16'h5678, 4'b0000, 4'b0000, 1'b1, 0, 21, -1,
                 16'h0, 4'b0, 4'b0);

        // 5: drop enable in digit 2 SHOW (cycle 21)
        chk("anode before drop", 32'(anode), 32'h4);
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk($sformatf("dropped anode %0d", i), 32'(anode), 32'h0);
            chk($sformatf("dropped frame %0d", i), 32'(frame), 32'h0);
        end
        enable = 1'b1;
        @(negedge clock);
        run_span(16'h5678, 4'b0000, 4'b0000, 1'b0, 0, 11, -1,
                 16'h0, 4'b0, 4'b0);

        // 6: asynchronous reset between edges during digit 1 SHOW
        chk("anode before reset", 32'(anode), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("async anode", 32'(anode), 32'h0);
        chk("async num", 32'(num), 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("post reset outs %0d", i), 32'({num, dp, anode, frame}), 32'h0);
        end
        enable = 1'b1;
        @(negedge clock);
        run_span(16'h0000, 4'b0000, 4'b0000, 1'b0, 0, 10, -1,
                 16'h0, 4'b0, 4'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
